// File: rtl/cdp1802_dma_responder.sv
// 1802 machine-cycle sequencer: S2 DMA-out and S3 interrupt insertion
// Owns R0 as the DMA pointer and feeds the display data bus.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   clk_enable            CPU tick; all state advances only on ticks
//   dma_out_n             DMA-out request from display (active-low)
//   int_req, ie           interrupt request and enable flag
//   core_sc               cycle type the core wants next
//   core_instr_end        last S1 cycle of an instruction, phase 7
//   r0_load, r0_load_val  core write of R0 (CPU state only)
//   mem_data_in           read data, one tick after mem_rd_en
//   SC, phase             current state code and phase
//   core_hold             core frozen during S2/S3
//   r0, mem_addr          DMA pointer and memory address
//   mem_rd_en             one-tick read strobe
//   data_out, data_valid  byte to display, valid phases 4-7
//   int_ack, ie_clear     pulses at phase 0 of S3
module cdp1802_dma_responder #(
  parameter int CYCLE_TICKS = 8,
  parameter int RD_PHASE    = 1,
  parameter int CAP_PHASE   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        dma_out_n,
  input  logic        int_req,
  input  logic        ie,
  input  logic [1:0]  core_sc,
  input  logic        core_instr_end,
  input  logic        r0_load,
  input  logic [15:0] r0_load_val,
  input  logic [7:0]  mem_data_in,
  output logic [1:0]  SC,
  output logic [2:0]  phase,
  output logic        core_hold,
  output logic [15:0] r0,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        int_ack,
  output logic        ie_clear
);

  localparam logic [2:0] LAST  = 3'(CYCLE_TICKS - 1);
  localparam logic [2:0] RD_PH = 3'(RD_PHASE);
  localparam logic [2:0] CAP_PH = 3'(CAP_PHASE);
  localparam logic [2:0] VAL_PH = 3'd4;

  typedef enum logic [1:0] {
    ST_CPU,
    ST_DMA,
    ST_INT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  phase_nxt;
  logic [1:0]  sc_nxt;
  logic [15:0] r0_nxt;
  logic        wrap;
  logic        eval;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CPU;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration happens only at the end of an instruction's last
  // S1 cycle or at the end of any inserted S2/S3 cycle.
  always_comb begin
    wrap      = clk_enable && (phase == LAST);
    eval      = wrap && ((state != ST_CPU) ||
                ((SC == 2'b01) && core_instr_end));
    phase_nxt = phase;
    state_nxt = state;
    sc_nxt    = SC;
    r0_nxt    = r0;
    if (clk_enable) begin
      phase_nxt = wrap ? 3'd0 : phase + 3'd1;
    end
    if (wrap) begin
      state_nxt = ST_CPU;
      if (eval) begin
        if (!dma_out_n) begin
          state_nxt = ST_DMA;
        end else if (int_req && ie && state != ST_INT) begin
          state_nxt = ST_INT;
        end
      end
      unique case (state_nxt)
        ST_DMA:  sc_nxt = 2'b10;
        ST_INT:  sc_nxt = 2'b11;
        default: sc_nxt = core_sc;
      endcase
    end
    if (clk_enable) begin
      if (state == ST_DMA && phase == LAST) begin
        r0_nxt = r0 + 16'd1;
      end else if (state == ST_CPU && r0_load) begin
        r0_nxt = r0_load_val;
      end
    end
  end

  // Outputs are registered from next-state values so each one
  // lines up with the phase it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= 3'd0;
      SC         <= 2'b00;
      core_hold  <= 1'b0;
      r0         <= 16'h0000;
      mem_addr   <= 16'h0000;
      mem_rd_en  <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      int_ack    <= 1'b0;
      ie_clear   <= 1'b0;
    end else if (clk_enable) begin
      phase      <= phase_nxt;
      r0         <= r0_nxt;
      mem_rd_en  <= (state_nxt == ST_DMA) && (phase_nxt == RD_PH);
      data_valid <= (state_nxt == ST_DMA) && (phase_nxt >= VAL_PH);
      int_ack    <= (state_nxt == ST_INT) && (phase_nxt == 3'd0);
      ie_clear   <= (state_nxt == ST_INT) && (phase_nxt == 3'd0);
      if (wrap) begin
        SC        <= sc_nxt;
        core_hold <= (state_nxt != ST_CPU);
        mem_addr  <= r0_nxt;
      end
      if (state == ST_DMA && phase == CAP_PH) begin
        data_out <= mem_data_in;
      end
    end
  end

endmodule

// File: tb/tb_cdp1802_dma_responder.sv
// Testbench for cdp1802_dma_responder
// Scoreboard of expected DMA bytes checked at phase 4 of each S2.
module tb_cdp1802_dma_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b0;
  logic        dma_out_n = 1'b1;
  logic        int_req = 1'b0;
  logic        ie = 1'b0;
  logic [1:0]  core_sc = 2'b01;
  logic        core_instr_end = 1'b0;
  logic        r0_load = 1'b0;
  logic [15:0] r0_load_val = 16'h0;
  logic [7:0]  mem_data_in;
  logic [1:0]  SC;
  logic [2:0]  phase;
  logic        core_hold;
  logic [15:0] r0;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        int_ack;
  logic        ie_clear;

  always #5 clk = ~clk;

  cdp1802_dma_responder dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .dma_out_n(dma_out_n), .int_req(int_req), .ie(ie),
    .core_sc(core_sc), .core_instr_end(core_instr_end),
    .r0_load(r0_load), .r0_load_val(r0_load_val),
    .mem_data_in(mem_data_in), .SC(SC), .phase(phase),
    .core_hold(core_hold), .r0(r0), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .data_out(data_out),
    .data_valid(data_valid), .int_ack(int_ack),
    .ie_clear(ie_clear)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] mem_q = 8'h00;
  assign mem_data_in = mem_q;

  always @(posedge clk) begin
    if (clk_enable && mem_rd_en) mem_q <= mem[mem_addr];
  end

  logic [2:0] last_ph = 3'd0;
  always @(negedge clk) begin
    if (data_valid && phase == 3'd4 && last_ph != 3'd4) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected got addr=%h data=%h",
                 mem_addr, data_out);
      end else begin
        got_e = sb.pop_front();
        if (data_out !== got_e.data || mem_addr !== got_e.addr) begin
          n_bad++;
          $display("FAIL sb_data got %h@%h want %h@%h",
                   data_out, mem_addr, got_e.data, got_e.addr);
        end
      end
    end
    last_ph = phase;
  end

  task automatic tick();
    clk_enable = 1'b1;
    @(posedge clk);
    #1;
    clk_enable = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] a);
    exp_t x;
    x.addr = a;
    x.data = mem[a];
    sb.push_back(x);
  endtask

  task automatic run_to_phase(input logic [2:0] p);
    int n;
    n = 0;
    while (phase !== p && n < 20) begin
      tick();
      n++;
    end
    if (phase !== p) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_to_phase got %0d want %0d", phase, p);
    end
  endtask

  task automatic load_r0(input logic [15:0] v);
    r0_load = 1'b1;
    r0_load_val = v;
    tick();
    r0_load = 1'b0;
  endtask

  task automatic enter_boundary();
    run_to_phase(3'd7);
    core_instr_end = 1'b1;
    tick();
    core_instr_end = 1'b0;
  endtask

  task automatic test_reset();
    logic [49:0] v;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    v = {SC, phase, r0, mem_addr, data_out, core_hold,
         mem_rd_en, data_valid, int_ack, ie_clear};
    n_cmp++;
    if (v !== 50'd0) begin
      n_bad++;
      $display("FAIL reset_vals got %h want 0", v);
    end
    repeat (8) tick();
    n_cmp++;
    if (SC !== 2'b01 || phase !== 3'd0) begin
      n_bad++;
      $display("FAIL sc_follow got %b/%0d want 01/0", SC, phase);
    end
  endtask

  task automatic test_single_dma();
    mem[16'h0900] = 8'hA5;
    load_r0(16'h0900);
    n_cmp++;
    if (r0 !== 16'h0900) begin
      n_bad++;
      $display("FAIL r0_load got %h want 0900", r0);
    end
    dma_out_n = 1'b0;
    enter_boundary();
    push_exp(16'h0900);
    n_cmp++;
    if (SC !== 2'b10 || mem_addr !== 16'h0900 || !core_hold) begin
      n_bad++;
      $display("FAIL s2_enter got %b %h %b want 10 0900 1",
               SC, mem_addr, core_hold);
    end
    dma_out_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (data_valid !== (phase >= 3'd4) ||
          mem_rd_en !== (phase == 3'd1)) begin
        n_bad++;
        $display("FAIL s2_strobes ph%0d got dv=%b rd=%b",
                 phase, data_valid, mem_rd_en);
      end
      tick();
    end
    n_cmp++;
    if (SC !== 2'b01 || r0 !== 16'h0901 || core_hold !== 1'b0 ||
        data_out !== 8'hA5) begin
      n_bad++;
      $display("FAIL s2_exit got %b %h %b %h want 01 0901 0 a5",
               SC, r0, core_hold, data_out);
    end
  endtask

  task automatic test_burst();
    int hold;
    for (int k = 0; k < 8; k++) begin
      mem[16'h0900 + 16'(k)] = 8'(k + 1);
      push_exp(16'h0900 + 16'(k));
    end
    load_r0(16'h0900);
    dma_out_n = 1'b0;
    enter_boundary();
    hold = 0;
    for (int t = 0; t < 80; t++) begin
      if (t == 56) dma_out_n = 1'b1;
      if (core_hold) hold++;
      tick();
    end
    n_cmp++;
    if (hold != 64) begin
      n_bad++;
      $display("FAIL burst_hold got %0d want 64", hold);
    end
    n_cmp++;
    if (r0 !== 16'h0908 || SC !== 2'b01) begin
      n_bad++;
      $display("FAIL burst_end got %h %b want 0908 01", r0, SC);
    end
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'h5A;
    load_r0(16'hFFFF);
    dma_out_n = 1'b0;
    enter_boundary();
    push_exp(16'hFFFF);
    dma_out_n = 1'b1;
    n_cmp++;
    if (mem_addr !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_addr got %h want ffff", mem_addr);
    end
    repeat (8) tick();
    n_cmp++;
    if (r0 !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_r0 got %h want 0000", r0);
    end
  endtask

  task automatic test_priority();
    mem[16'h0A00] = 8'h3C;
    mem[16'h0A01] = 8'h77;
    load_r0(16'h0A00);
    dma_out_n = 1'b0;
    int_req = 1'b1;
    ie = 1'b1;
    enter_boundary();
    push_exp(16'h0A00);
    n_cmp++;
    if (SC !== 2'b10) begin
      n_bad++;
      $display("FAIL prio_dma got %b want 10", SC);
    end
    dma_out_n = 1'b1;
    repeat (8) tick();
    n_cmp++;
    if (SC !== 2'b11 || !int_ack || !ie_clear || !core_hold) begin
      n_bad++;
      $display("FAIL s3_enter got %b %b %b %b want 11 1 1 1",
               SC, int_ack, ie_clear, core_hold);
    end
    tick();
    n_cmp++;
    if (int_ack !== 1'b0 || ie_clear !== 1'b0) begin
      n_bad++;
      $display("FAIL s3_pulse got %b %b want 0 0", int_ack, ie_clear);
    end
    repeat (7) tick();
    n_cmp++;
    if (SC !== 2'b01 || r0 !== 16'h0A01) begin
      n_bad++;
      $display("FAIL s3_exit got %b %h want 01 0a01", SC, r0);
    end
    ie = 1'b0;
    dma_out_n = 1'b0;
    enter_boundary();
    push_exp(16'h0A01);
    dma_out_n = 1'b1;
    repeat (8) tick();
    n_cmp++;
    if (SC !== 2'b01 || int_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL ie_off got %b %b want 01 0", SC, int_ack);
    end
    int_req = 1'b0;
  endtask

  task automatic test_reset_mid_dma();
    load_r0(16'h0900);
    dma_out_n = 1'b0;
    enter_boundary();
    push_exp(16'h0900);
    dma_out_n = 1'b1;
    run_to_phase(3'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (SC !== 2'b00 || r0 !== 16'h0000 || data_valid !== 1'b0 ||
        phase !== 3'd0 || core_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid got %b %h %b %0d want 00 0000 0 0",
               SC, r0, data_valid, phase);
    end
    repeat (10) tick();
    n_cmp++;
    if (r0 !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_noinc got %h want 0000", r0);
    end
  endtask

  task automatic test_gaps();
    logic [49:0] snap;
    logic [49:0] now;
    mem[16'h0B00] = 8'hC3;
    load_r0(16'h0B00);
    dma_out_n = 1'b0;
    enter_boundary();
    push_exp(16'h0B00);
    dma_out_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clk_enable = 1'b1;
      @(posedge clk); #1;
      clk_enable = 1'b0;
      snap = {SC, phase, r0, mem_addr, data_out, core_hold,
              mem_rd_en, data_valid, int_ack, ie_clear};
      repeat (2) begin
        @(posedge clk); #1;
      end
      now = {SC, phase, r0, mem_addr, data_out, core_hold,
             mem_rd_en, data_valid, int_ack, ie_clear};
      n_cmp++;
      if (now !== snap ||
          (i < 7 && data_valid !== (phase >= 3'd4))) begin
        n_bad++;
        $display("FAIL gap_hold got %h want %h", now, snap);
      end
    end
    n_cmp++;
    if (r0 !== 16'h0B01 || SC !== 2'b01 || data_out !== 8'hC3) begin
      n_bad++;
      $display("FAIL gap_end got %h %b %h want 0b01 01 c3",
               r0, SC, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_dma();
    test_burst();
    test_wrap();
    test_priority();
    test_reset_mid_dma();
    test_gaps();
    repeat (4) tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_left got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdp1802_dma_responder.md
# cdp1802_dma_responder

CPU-side responder for the 1861 display's DMA-out and interrupt requests. It sequences the 1802 machine-cycle state code (SC), inserts S2 DMA-out cycles that read M(R0) and drive the byte onto the display data bus, and inserts S3 interrupt cycles. It sits between the CPU core's instruction sequencer and the display block, and owns R0 as the DMA pointer.

## Interface
Parameters:
- `CYCLE_TICKS`, 8: `clk_enable` ticks per machine cycle; phase counter wraps at `CYCLE_TICKS-1`.
- `RD_PHASE`, 1: phase in which `mem_rd_en` is asserted.
- `CAP_PHASE`, 3: phase in which `mem_data_in` is captured.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `clk_enable` in 1: CPU tick; all state advances only on ticks.
- `dma_out_n` in 1: DMA-out request from the display, active-low, level.
- `int_req` in 1: interrupt request, active-high, level.
- `ie` in 1: interrupt-enable flag from the core.
- `core_sc` in 2: cycle type the core wants next (00 fetch, 01 execute).
- `core_instr_end` in 1: high during phase 7 of the last S1 cycle of an instruction.
- `r0_load` in 1: core writes R0 this tick.
- `r0_load_val` in 16: value for `r0_load`.
- `mem_data_in` in 8: memory read data, valid one tick after `mem_rd_en`.
- `SC` out 2: current machine-cycle state code.
- `phase` out 3: phase within the machine cycle.
- `core_hold` out 1: core frozen; high throughout S2 and S3.
- `r0` out 16: DMA pointer.
- `mem_addr` out 16: equals `r0` during S2.
- `mem_rd_en` out 1: one-tick memory read strobe.
- `data_out` out 8: byte driven to the display.
- `data_valid` out 1: high phases 4–7 of S2.
- `int_ack` out 1: one-tick pulse at phase 0 of S3.
- `ie_clear` out 1: one-tick pulse with `int_ack`.

## Operation
- States: CPU (SC = `core_sc`), DMA (SC=10), INT (SC=11).
- Arbitration is evaluated only on the phase-7 tick of a cycle that is an S1 cycle with `core_instr_end`=1, an S2 cycle, or an S3 cycle:
  - If `dma_out_n`=0, the next state is DMA.
  - Otherwise, if `int_req`=1 and `ie`=1, the next state is INT. An S3 cycle never chains into another S3 cycle.
  - Otherwise, the next state is CPU.
- DMA has strict priority over INT. A request present at the same boundary as an interrupt always yields S2 first, and INT is re-evaluated at the end of each S2 cycle.
- S2 cycle sequence:
  - `mem_rd_en`=1 at `RD_PHASE`.
  - At `CAP_PHASE`, `data_out` <= `mem_data_in`.
  - `data_valid`=1 during phases 4–7.
  - At phase 7, `r0` <= `r0`+1, modulo 2^16 (0xFFFF wraps to 0x0000).
- S3 cycle: `int_ack` and `ie_clear` pulse at phase 0. There is no memory access and `r0` is unchanged.
- `r0_load` is honoured only in the CPU state. It is ignored in S2/S3.
- `dma_out_n` and `int_req` changes mid-cycle have no effect until the next evaluation point. A deasserted request at phase 7 ends the burst.

## Timing
- Reset values: `SC`=00, `phase`=0, state CPU, `r0`=0x0000, `mem_addr`=0x0000, `data_out`=0x00, `core_hold`, `mem_rd_en`, `data_valid`, `int_ack`, `ie_clear` all 0.
- Reset during S2 aborts the cycle. No increment or capture completes, and the next tick starts phase 0 in CPU.
- `SC`, `core_hold` and `mem_addr` change on the tick where `phase` wraps 7→0. All outputs are registered.
- `data_out` is stable from phase 4 of S2 until the next capture.
- Without ticks, every register holds.
- Memory latency is exactly one tick. The sample taken at `CAP_PHASE` is the data returned by the `RD_PHASE` strobe.
- Burst of N consecutive S2 cycles: `r0` advances by N, and the core is held for N×`CYCLE_TICKS` ticks.

## Test plan
- Single DMA: load `r0`=0x0900, mem[0x0900]=0xA5, `dma_out_n`=0 before `core_instr_end` → next cycle `SC`=10, `mem_addr`=0x0900, `data_out`=0xA5 with `data_valid` phases 4–7, `r0`=0x0901 after the cycle, then `SC` returns to `core_sc`.
- Burst: `dma_out_n` held low for 8 cycles over mem[0x0900..0x0907]=0x01..0x08 → eight S2 cycles, `data_out` sequence 01..08, `r0`=0x0908, `core_hold` high for 64 ticks.
- Wrap: `r0`=0xFFFF, one DMA → reads 0xFFFF, then `r0`=0x0000.
- Priority: `dma_out_n`=0 and `int_req`=1, `ie`=1 at the same boundary → one S2 cycle (request released), then S3 with an `int_ack` pulse, then CPU. With `ie`=0 → no S3.
- Reset at phase 4 of S2 with `r0`=0x0900 → `SC`=00, `r0`=0x0000, `data_valid`=0 on the next tick, and no increment.
- Gaps: `clk_enable` high only every 3rd clk during a DMA → identical results, with all outputs frozen between ticks.
